// File: rtl/mem_port_responder_pkg.sv
// Shared definitions for the memory-side responder.
//   ADDR_W_DEF / DATA_W_DEF / RAM_LAT_DEF : default widths and RAM read latency
//   resp_state_e                          : responder FSM state encoding
package mem_port_responder_pkg;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned RAM_LAT_DEF = 2;

   typedef enum logic [1:0] {
      RESP_IDLE     = 2'd0,
      RESP_RD_ISSUE = 2'd1,
      RESP_RD_WAIT  = 2'd2
   } resp_state_e;

endpackage

// File: rtl/mem_port_responder_wbuf.sv
// One-entry posted write buffer.
//   clk, rst_n   : clock, async active-low reset (discards the buffered write)
//   capture      : load cap_addr/cap_data and mark the entry full
//   drain        : entry is being written to RAM this cycle; clears full unless refilled
//   lookup_addr  : address compared against the buffered entry
//   full, hit    : entry valid; entry valid and address matches
//   buf_addr/data: buffered address/data (RAM drain source and read forwarding)
module mem_port_responder_wbuf
   import mem_port_responder_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic              drain,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              full,
   output logic              hit,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_data
);

   logic              full_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (capture) begin
         // Capture wins over drain: old entry leaves, new one lands on the same edge.
         full_q <= 1'b1;
         addr_q <= cap_addr;
         data_q <= cap_data;
      end else if (drain) begin
         full_q <= 1'b0;
      end
   end

   assign full     = full_q;
   assign hit      = full_q & (lookup_addr == addr_q);
   assign buf_addr = addr_q;
   assign buf_data = data_q;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder for the multicycle CPU control path.
//   CLK, RESET_N        : clock, async active-low reset
//   Req/We/Addr/WData   : single access request from the datapath, held until accepted
//   Perform             : access accepted this edge / CPU may advance (0 = stall)
//   RData/RValid        : registered read data and its one-cycle valid pulse
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : fixed-latency single-port RAM
module mem_port_responder
   import mem_port_responder_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              Req,
   input  logic              We,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic              Perform,
   output logic [DATA_W-1:0] RData,
   output logic              RValid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int unsigned CntW = $clog2(RAM_LAT + 1);

   resp_state_e       state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   logic              perform_c;
   logic              drain_now;
   logic              wb_capture;
   logic              wb_full;
   logic              wb_hit;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   mem_port_responder_wbuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wbuf (
      .clk         (CLK),
      .rst_n       (RESET_N),
      .capture     (wb_capture),
      .drain       (drain_now),
      .cap_addr    (Addr),
      .cap_data    (WData),
      .lookup_addr (Addr),
      .full        (wb_full),
      .hit         (wb_hit),
      .buf_addr    (wb_addr),
      .buf_data    (wb_data)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_addr_d  = rd_addr_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      perform_c  = 1'b0;
      wb_capture = 1'b0;
      // Buffered write drains whenever the FSM is idle, so reads never collide with it.
      drain_now  = wb_full & (state_q == RESP_IDLE);
      ram_en     = drain_now;
      ram_we     = drain_now;
      ram_addr   = wb_addr;
      ram_wdata  = wb_data;

      unique case (state_q)
         RESP_IDLE: begin
            if (We) begin
               perform_c = ~wb_full | drain_now;
            end else begin
               // A miss must wait for the pending write to reach RAM first.
               perform_c = wb_hit | ~wb_full;
            end
            if (Req && perform_c) begin
               if (We) begin
                  wb_capture = 1'b1;
               end else if (wb_hit) begin
                  rdata_d  = wb_data;
                  rvalid_d = 1'b1;
               end else begin
                  rd_addr_d = Addr;
                  state_d   = RESP_RD_ISSUE;
               end
            end
         end
         RESP_RD_ISSUE: begin
            ram_en   = 1'b1;
            ram_we   = 1'b0;
            ram_addr = rd_addr_q;
            cnt_d    = CntW'(RAM_LAT);
            state_d  = RESP_RD_WAIT;
         end
         RESP_RD_WAIT: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               rdata_d  = ram_rdata;
               rvalid_d = 1'b1;
               state_d  = RESP_IDLE;
            end
         end
         default: begin
            state_d = RESP_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= RESP_IDLE;
         cnt_q     <= '0;
         rd_addr_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // Reset gates Perform directly so the CPU sees a stall for the whole reset pulse.
   assign Perform = perform_c & RESET_N;
   assign RData   = rdata_q;
   assign RValid  = rvalid_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder with a behavioural fixed-latency RAM.
module tb_mem_port_responder;

   localparam int unsigned LAT = 2;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        Req = 1'b0;
   logic        We = 1'b0;
   logic [15:0] Addr = '0;
   logic [15:0] WData = '0;
   logic        Perform;
   logic [15:0] RData;
   logic        RValid;
   logic        ram_en;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   mem_port_responder #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .RAM_LAT (LAT)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .Req       (Req),
      .We        (We),
      .Addr      (Addr),
      .WData     (WData),
      .Perform   (Perform),
      .RData     (RData),
      .RValid    (RValid),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural RAM: writes land at the edge, reads appear LAT cycles after the command.
   logic [15:0] ram_mem [256];
   logic [15:0] ref_mem [256];
   logic [15:0] rd_pipe [LAT];

   always @(posedge CLK) begin
      if (ram_en && ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
      rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[LAT-1];

   // Scoreboards: expected read data and (in directed tests) expected RAM command order.
   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } ram_op_t;

   logic [15:0] exp_rd_q [$];
   ram_op_t     exp_ram_q [$];
   bit          ram_chk = 1'b0;
   logic [15:0] mon_rd;
   ram_op_t     mon_op;

   always @(negedge CLK) begin
      if (RESET_N) begin
         if (RValid) begin
            if (exp_rd_q.size() == 0) begin
               check("rvalid_unexpected", 32'(RValid), 32'd0);
            end else begin
               mon_rd = exp_rd_q.pop_front();
               check("rdata", 32'(RData), 32'(mon_rd));
            end
         end
         if (ram_chk && ram_en) begin
            if (exp_ram_q.size() == 0) begin
               check("ram_unexpected", 32'(ram_en), 32'd0);
            end else begin
               mon_op = exp_ram_q.pop_front();
               check("ram_we", 32'(ram_we), 32'(mon_op.we));
               check("ram_addr", 32'(ram_addr), 32'(mon_op.addr));
               if (mon_op.we) check("ram_wdata", 32'(ram_wdata), 32'(mon_op.data));
            end
         end
      end
   end

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic do_access(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            output int waits);
      bit acc;
      acc   = 1'b0;
      waits = 0;
      Req   = 1'b1;
      We    = wr;
      Addr  = a;
      WData = d;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (Perform === 1'b1) begin
            acc = 1'b1;
            break;
         end
         waits++;
      end
      if (!acc) begin
         check("accept_timeout", 32'(Perform), 32'd1);
         Req = 1'b0;
         return;
      end
      if (wr) ref_mem[a[7:0]] = d;
      else    exp_rd_q.push_back(ref_mem[a[7:0]]);
      @(posedge CLK);
      #1;
      Req = 1'b0;
      We  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic push_op(input logic wr, input logic [15:0] a, input logic [15:0] d);
      ram_op_t op;
      op.we   = wr;
      op.addr = a;
      op.data = d;
      exp_ram_q.push_back(op);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  w;
      bit  seen;
      logic        rw;
      logic [15:0] ra;
      logic [15:0] rd;

      for (int i = 0; i < 256; i++) begin
         ram_mem[i] <= 16'(i * 16'h0101) ^ 16'h5A5A;
         ref_mem[i]  = 16'(i * 16'h0101) ^ 16'h5A5A;
      end
      ram_mem[16'h10] <= 16'hBEEF; ref_mem[16'h10] = 16'hBEEF;
      ram_mem[16'h60] <= 16'h6060; ref_mem[16'h60] = 16'h6060;
      ram_mem[16'h70] <= 16'h7777; ref_mem[16'h70] = 16'h7777;

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_perform", 32'(Perform), 32'd0);
      check("rst_rvalid", 32'(RValid), 32'd0);
      check("rst_rdata", 32'(RData), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      #2 RESET_N = 1'b1;
      #1 check("rel_perform", 32'(Perform), 32'd1);
      @(posedge CLK);
      #1;

      // 1: read miss, RAM latency and stall window
      ram_chk = 1'b1;
      push_op(1'b0, 16'h0010, 16'h0);
      do_access(1'b0, 16'h0010, 16'h0, w);
      check("t1_wait", 32'(w), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         check("t1_perform", 32'(Perform), 32'(k == 4));
         check("t1_ram_en", 32'(ram_en), 32'(k == 1));
         check("t1_rvalid", 32'(RValid), 32'(k == 4));
      end
      check("t1_rdata", 32'(RData), 32'hBEEF);
      idle(1);

      // 2: posted write drains in the following cycle
      push_op(1'b1, 16'h0020, 16'h1234);
      do_access(1'b1, 16'h0020, 16'h1234, w);
      check("t2_wait", 32'(w), 32'd0);
      @(negedge CLK);
      check("t2_ram_en", 32'(ram_en), 32'd1);
      check("t2_ram_we", 32'(ram_we), 32'd1);
      check("t2_ram_addr", 32'(ram_addr), 32'h0020);
      check("t2_ram_wdata", 32'(ram_wdata), 32'h1234);
      idle(2);

      // 3: read hits the buffered write, no RAM read
      push_op(1'b1, 16'h0030, 16'hAAAA);
      do_access(1'b1, 16'h0030, 16'hAAAA, w);
      do_access(1'b0, 16'h0030, 16'h0, w);
      check("t3_hit_wait", 32'(w), 32'd0);
      @(negedge CLK);
      check("t3_rvalid", 32'(RValid), 32'd1);
      check("t3_rdata", 32'(RData), 32'hAAAA);
      check("t3_ram_en", 32'(ram_en), 32'd0);
      idle(3);
      check("t3_ram_q", 32'(exp_ram_q.size()), 32'd0);

      // 4: back-to-back writes (drain + refill on the same edge)
      push_op(1'b1, 16'h0040, 16'h0001);
      push_op(1'b1, 16'h0041, 16'h0002);
      do_access(1'b1, 16'h0040, 16'h0001, w);
      check("t4_wait0", 32'(w), 32'd0);
      do_access(1'b1, 16'h0041, 16'h0002, w);
      check("t4_wait1", 32'(w), 32'd0);
      idle(3);
      check("t4_ram_q", 32'(exp_ram_q.size()), 32'd0);

      // 5: read miss behind a pending write stalls exactly one cycle
      push_op(1'b1, 16'h0050, 16'h0007);
      push_op(1'b0, 16'h0060, 16'h0);
      do_access(1'b1, 16'h0050, 16'h0007, w);
      do_access(1'b0, 16'h0060, 16'h0, w);
      check("t5_drain_stall", 32'(w), 32'd1);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (RValid) begin
            seen = 1'b1;
            break;
         end
      end
      check("t5_rvalid_seen", 32'(seen), 32'd1);
      idle(1);
      check("t5_ram_q", 32'(exp_ram_q.size()), 32'd0);
      check("t5_rd_q", 32'(exp_rd_q.size()), 32'd0);

      // 6: reset while the read is in RD_WAIT
      push_op(1'b0, 16'h0070, 16'h0);
      do_access(1'b0, 16'h0070, 16'h0, w);
      repeat (3) @(negedge CLK);
      #2 RESET_N = 1'b0;
      exp_rd_q.delete();
      #1;
      check("t6_ram_en", 32'(ram_en), 32'd0);
      check("t6_rvalid", 32'(RValid), 32'd0);
      check("t6_perform", 32'(Perform), 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #2 RESET_N = 1'b1;
      #1 check("t6_rel_perform", 32'(Perform), 32'd1);
      check("t6_rdata_rst", 32'(RData), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         check("t6_no_stale", 32'(RValid), 32'd0);
      end
      @(posedge CLK);
      #1;

      // Mixed random traffic over a small address window; read data via scoreboard
      ram_chk = 1'b0;
      exp_ram_q.delete();
      for (int n = 0; n < 40; n++) begin
         rw = 1'($urandom_range(0, 1));
         ra = 16'h0080 + 16'($urandom_range(0, 7));
         rd = 16'($urandom);
         do_access(rw, ra, rd, w);
         if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(10);
      check("rand_rd_q", 32'(exp_rd_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
